// File: rtl/gps_stream_arbiter.sv
// gps_stream_arbiter: grants one GPZDA receiver to one of two byte streams for a whole sentence,
// paces receiver loads, aborts on timeout or a restarting '$', and reports one tagged completion per sentence.
module gps_stream_arbiter #(
    parameter int B       = 8,
    parameter int Timeout = 100000,
    parameter int LoadGap = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in0_valid,
    input  logic [B-1:0] in0_data,
    output logic         in0_ready,
    input  logic         in1_valid,
    input  logic [B-1:0] in1_data,
    output logic         in1_ready,
    output logic         rx_load,
    output logic [B-1:0] rx_data,
    output logic         rx_abort,
    input  logic         rx_resolve,
    input  logic         rx_error,
    output logic         done,
    output logic         done_src,
    output logic [1:0]   done_status,
    output logic         busy
);
    localparam int GW = $clog2(LoadGap);
    localparam int IW = $clog2(Timeout + 1);
    localparam logic [B-1:0] Dollar  = B'(8'h24);
    localparam logic [B-1:0] Newline = B'(8'h0A);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, ABORT} state_t;

    state_t        r_state, w_next;
    logic          r_grant, r_prio, r_load, r_done, r_done_src;
    logic [B-1:0]  r_data;
    logic [1:0]    r_status, r_done_status;
    logic [GW-1:0] r_gap;
    logic [IW-1:0] r_idle;
    logic          w_gap_zero, w_timeout, w_cand, w_sel, w_sel_valid, w_sel_ready;
    logic          w_take, w_dollar, w_newline, w_fwd, w_feed_dollar;
    logic [1:0]    w_abort_status;
    logic [B-1:0]  w_sel_data;

    // In IDLE the preferred source wins unless only the other one has a byte.
    assign w_cand         = ((r_prio ? in1_valid : in0_valid) || !(r_prio ? in0_valid : in1_valid)) ? r_prio : !r_prio;
    assign w_sel          = (r_state == IDLE) ? w_cand : r_grant;
    assign w_sel_valid    = w_sel ? in1_valid : in0_valid;
    assign w_sel_data     = w_sel ? in1_data : in0_data;
    assign w_gap_zero     = r_gap == '0;
    assign w_timeout      = r_idle == IW'(Timeout);
    assign w_dollar       = w_sel_data == Dollar;
    assign w_newline      = w_sel_data == Newline;
    assign w_take         = w_sel_valid && w_sel_ready;
    assign w_feed_dollar  = (r_state == FEED) && w_sel_valid && w_dollar;
    assign w_fwd          = w_take && (r_state == FEED || (r_state == IDLE && w_dollar));
    assign w_abort_status = w_feed_dollar ? 2'd3 : 2'd2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_fwd ? FEED : IDLE;
            FEED:    w_next = rx_resolve ? DRAIN : ((w_feed_dollar || w_timeout) ? ABORT : FEED);
            DRAIN:   w_next = ((w_take && w_newline) || w_timeout) ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    // A '$' inside a sentence is left unconsumed so the restarted sentence can replay it.
    always_comb begin
        w_sel_ready = 1'b0;
        case (r_state)
            IDLE:    w_sel_ready = w_gap_zero;
            FEED:    w_sel_ready = w_gap_zero && !w_dollar && !rx_resolve;
            DRAIN:   w_sel_ready = 1'b1;
            default: w_sel_ready = 1'b0;
        endcase
        in0_ready = w_sel_ready && !w_sel;
        in1_ready = w_sel_ready && w_sel;
        rx_abort  = r_state == ABORT;
        busy      = r_state != IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_grant       <= 1'b0;
            r_prio        <= 1'b0;
            r_load        <= 1'b0;
            r_data        <= '0;
            r_gap         <= '0;
            r_idle        <= '0;
            r_status      <= 2'd0;
            r_done        <= 1'b0;
            r_done_src    <= 1'b0;
            r_done_status <= 2'd0;
        end else begin
            r_load <= w_fwd;
            if (w_fwd) r_data <= w_sel_data;
            r_gap <= w_fwd ? GW'(LoadGap - 1) : (w_gap_zero ? r_gap : r_gap - 1'b1);
            if (r_state == FEED || r_state == DRAIN) r_idle <= w_take ? '0 : (w_timeout ? r_idle : r_idle + 1'b1);
            else r_idle <= '0;
            if (r_state == IDLE && w_fwd) r_grant <= w_sel;
            r_done <= 1'b0;
            if (r_state == FEED && w_next == DRAIN) r_status <= {1'b0, rx_error};
            if (r_state == FEED && w_next == ABORT) begin
                r_status      <= w_abort_status;
                r_done        <= 1'b1;
                r_done_src    <= r_grant;
                r_done_status <= w_abort_status;
            end
            if (r_state == DRAIN && w_next == IDLE) begin
                r_done        <= 1'b1;
                r_done_src    <= r_grant;
                r_done_status <= r_status;
                if (w_take && w_newline) r_prio <= !r_grant;
            end
            // Only a timeout hands priority away; a '$' restart lets the same source win again.
            if (r_state == ABORT && r_status == 2'd2) r_prio <= !r_grant;
        end
    end

    assign rx_load     = r_load;
    assign rx_data     = r_data;
    assign done        = r_done;
    assign done_src    = r_done_src;
    assign done_status = r_done_status;
endmodule

// File: tb/tb_gps_stream_arbiter.sv
// tb_gps_stream_arbiter: scoreboard bench for gps_stream_arbiter with two queued byte sources
// and a small receiver model that resolves two bytes after '*'.
module tb_gps_stream_arbiter;
    localparam int B  = 8;
    localparam int TO = 50;
    localparam int LG = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in0_valid = 1'b0, in1_valid = 1'b0;
    logic [7:0] in0_data = 8'h00, in1_data = 8'h00;
    logic       in0_ready, in1_ready, rx_load, rx_abort, done, done_src, busy;
    logic [7:0] rx_data;
    logic       rx_resolve = 1'b0, rx_error = 1'b0;
    logic [1:0] done_status;

    gps_stream_arbiter #(.B(B), .Timeout(TO), .LoadGap(LG)) dut (
        .clock(clock), .reset(reset),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .rx_load(rx_load), .rx_data(rx_data), .rx_abort(rx_abort),
        .rx_resolve(rx_resolve), .rx_error(rx_error),
        .done(done), .done_src(done_src), .done_status(done_status), .busy(busy)
    );

    always #5 clock = ~clock;

    logic [7:0] q0[$], q1[$], exp_load[$];
    logic [2:0] exp_done[$];
    int     n_pass = 0, n_total = 0, n_done = 0, n_loads = 0, n_abort = 0, n_gap_bad = 0, n_bad_ready = 0;
    longint cyc = 0, last_load_cyc = 0, abort_cyc = 0;
    bit     prev_load_ok = 0, strict = 0, watch_en = 0, watch_src = 0, bad = 0;
    logic   f0 = 1'b0, f1 = 1'b0;
    string  body = "$GPZDA,172809.456,12,07,1996,00,00*45";

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(posedge clock) begin
        cyc <= cyc + 1;
        f0  <= in0_valid && in0_ready && !reset;
        f1  <= in1_valid && in1_ready && !reset;
    end

    // Source drivers: pop on a completed handshake, present the next queued byte.
    initial forever begin
        @(negedge clock);
        if (f0) void'(q0.pop_front());
        if (f1) void'(q1.pop_front());
        in0_valid = q0.size() > 0;
        in0_data  = in0_valid ? q0[0] : 8'h00;
        in1_valid = q1.size() > 0;
        in1_data  = in1_valid ? q1[0] : 8'h00;
    end

    // Receiver model: resolves once both checksum characters after '*' have been loaded.
    initial begin
        bit star = 0;
        int cnt = 0;
        forever begin
            @(negedge clock);
            rx_resolve = 1'b0;
            rx_error   = 1'b0;
            if (reset || rx_abort) begin
                star = 0;
                cnt  = 0;
            end else if (rx_load) begin
                if (rx_data == 8'h24) begin
                    star = 0;
                    cnt  = 0;
                end else if (star) begin
                    cnt++;
                    if (cnt == 2) begin
                        rx_resolve = 1'b1;
                        rx_error   = bad;
                        star       = 0;
                    end
                end else if (rx_data == 8'h2A) star = 1;
            end
        end
    end

    // Monitor: pops expected loads and completions as the DUT presents them.
    initial forever begin
        @(negedge clock);
        #1;
        if (reset) prev_load_ok = 0;
        if (rx_load) begin
            n_loads++;
            check("load_expected", exp_load.size() != 0, 1);
            if (exp_load.size() != 0) check("rx_data", rx_data, exp_load.pop_front());
            if (prev_load_ok) begin
                check("load_gap_min", (cyc - last_load_cyc) >= LG, 1);
                if (strict && (cyc - last_load_cyc) != LG) n_gap_bad++;
            end
            prev_load_ok  = 1;
            last_load_cyc = cyc;
        end
        if (rx_abort) begin
            n_abort++;
            abort_cyc = cyc;
            check("abort_with_done", done, 1);
        end
        if (done) begin
            logic [2:0] e;
            n_done++;
            watch_en = 0;
            check("done_expected", exp_done.size() != 0, 1);
            if (exp_done.size() != 0) begin
                e = exp_done.pop_front();
                check("done_src", done_src, e[2]);
                check("done_status", done_status, e[1:0]);
            end
        end
        if (watch_en && (watch_src ? in1_ready : in0_ready)) n_bad_ready++;
    end

    task automatic push_src(input bit s, input string str, input bit crlf);
        for (int i = 0; i < str.len(); i++) begin
            if (s) q1.push_back(str[i]);
            else q0.push_back(str[i]);
        end
        if (crlf) begin
            if (s) begin q1.push_back(8'h0D); q1.push_back(8'h0A); end
            else begin q0.push_back(8'h0D); q0.push_back(8'h0A); end
        end
    endtask

    task automatic expect_bytes(input string str, input int n);
        for (int i = 0; i < n; i++) exp_load.push_back(str[i]);
    endtask

    task automatic expect_done(input bit s, input logic [1:0] st);
        exp_done.push_back({s, st});
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (n_done < target && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check("done_count", n_done, target);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total checks %0d", n_total);
        $fatal(1);
    end

    initial begin
        int ab, base, dn, k;
        repeat (3) @(negedge clock);
        #1;
        check("rst_rx_load", rx_load, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_abort", rx_abort, 0);
        check("rst_done", done, 0);
        check("rst_done_src", done_src, 0);
        check("rst_done_status", done_status, 0);
        check("rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        // Garbage then one sentence from source 0 at full rate
        strict = 1;
        push_src(0, "xx", 1);
        push_src(0, body, 1);
        expect_bytes(body, body.len());
        expect_done(0, 2'd0);
        wait_done(1);
        strict = 0;
        check("t1_gap_exact", n_gap_bad, 0);
        check("t1_load_count", n_loads, body.len());

        // Priority now with source 1: it wins a simultaneous start
        watch_src = 0;
        watch_en  = 1;
        push_src(1, body, 1);
        push_src(0, body, 1);
        expect_bytes(body, body.len());
        expect_bytes(body, body.len());
        expect_done(1, 2'd0);
        expect_done(0, 2'd0);
        wait_done(3);
        check("t2_src0_ready_held", n_bad_ready, 0);

        // Contention straight after reset: source 0 first
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        n_bad_ready = 0;
        watch_src   = 1;
        watch_en    = 1;
        push_src(0, body, 1);
        push_src(1, body, 1);
        expect_bytes(body, body.len());
        expect_bytes(body, body.len());
        expect_done(0, 2'd0);
        expect_done(1, 2'd0);
        wait_done(5);
        check("t3_src1_ready_held", n_bad_ready, 0);

        // Bad checksum on source 1
        ab  = n_abort;
        bad = 1;
        push_src(1, body, 1);
        expect_bytes(body, body.len());
        expect_done(1, 2'd1);
        wait_done(6);
        bad = 0;
        check("t4_no_abort", n_abort, ab);

        // Reset in the middle of a sentence
        base = n_loads;
        dn   = n_done;
        push_src(0, body, 1);
        expect_bytes(body, 5);
        k = 0;
        while (n_loads < base + 5 && k < 500) begin
            @(negedge clock);
            k++;
        end
        check("t7_loads_before_reset", n_loads, base + 5);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        check("t7_busy", busy, 0);
        check("t7_rx_load", rx_load, 0);
        check("t7_rx_data", rx_data, 0);
        check("t7_rx_abort", rx_abort, 0);
        check("t7_done_src", done_src, 0);
        check("t7_done_status", done_status, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("t7_no_done", n_done, dn);
        check("t7_idle_after", busy, 0);

        // Timeout after "$GPZ" on source 0
        ab = n_abort;
        push_src(0, "$GPZ", 0);
        expect_bytes("$GPZ", 4);
        expect_done(0, 2'd2);
        wait_done(7);
        check("t5_abort_pulses", n_abort, ab + 1);
        check("t5_timeout_cycles", abort_cyc - last_load_cyc, TO + 1);

        // Restart on '$' from source 1 while source 0 also waits
        ab = n_abort;
        push_src(1, "$GPZDA,12", 0);
        push_src(1, body, 1);
        push_src(0, body, 1);
        expect_bytes("$GPZDA,12", 9);
        expect_bytes(body, body.len());
        expect_bytes(body, body.len());
        expect_done(1, 2'd3);
        expect_done(1, 2'd0);
        expect_done(0, 2'd0);
        wait_done(10);
        check("t6_abort_pulses", n_abort, ab + 1);

        check("exp_load_empty", exp_load.size(), 0);
        check("exp_done_empty", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
